// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer in front of an 8-word registered-read data memory.
// Optional request counters are enabled by defining LSU_STATS_EN.
module lsu_mem_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic        [ADDR_W-1:0] req_addr,
   input  logic signed [DATA_W-1:0] req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic signed [DATA_W-1:0] rsp_rdata,
   output logic                     rsp_err,
   output logic                     mem_rw,
   output logic        [ADDR_W-1:0] mem_address,
   output logic signed [DATA_W-1:0] mem_data_in,
   input  logic signed [DATA_W-1:0] mem_data_out,
   input  logic                     mem_out_valid
`ifdef LSU_STATS_EN
   ,
   output logic              [7:0] stat_loads,
   output logic              [7:0] stat_stores,
   output logic              [7:0] stat_errs
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t                     state;
   logic                       lat_we;
   logic        [ADDR_W-1:0]   lat_addr;
   logic signed [DATA_W-1:0]   lat_wdata;
   logic                       xfer;
   logic                       in_range;

   assign req_ready   = (state == IDLE) && !clr;
   assign xfer        = req_valid && req_ready;
   assign in_range    = ({1'b0, req_addr} < DEPTH_C);
   assign mem_address = lat_addr;
   assign mem_data_in = lat_wdata;

   // mem_rw is registered so it is high exactly for the ISSUE cycle of a store.
   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         mem_rw    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  if (!in_range) begin
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     mem_rw <= req_we;
                     state  <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               mem_rw <= 1'b0;
               if (lat_we) begin
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  state <= CAPT;
               end
            end
            CAPT: begin
               rsp_rdata <= mem_data_out;
               rsp_err   <= ~mem_out_valid;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LSU_STATS_EN
   logic done;
   assign done = (state == RESP) && rsp_ready;

   // Counters advance on the response handshake and saturate at 255.
   always_ff @(posedge clk) begin
      if (clr) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_errs   <= '0;
      end else if (done) begin
         if (rsp_err) begin
            if (stat_errs != 8'hFF) stat_errs <= stat_errs + 8'd1;
         end else if (lat_we) begin
            if (stat_stores != 8'hFF) stat_stores <= stat_stores + 8'd1;
         end else begin
            if (stat_loads != 8'hFF) stat_loads <= stat_loads + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: attached memory model, directed steps plus random
// transactions checked against an array-based reference of the memory contents.
module tb_lsu_mem_ctrl;

   logic              clk = 1'b0;
   logic              clr;
   logic              req_valid, req_ready, req_we;
   logic        [3:0] req_addr;
   logic signed [7:0] req_wdata;
   logic              rsp_valid, rsp_ready, rsp_err;
   logic signed [7:0] rsp_rdata;
   logic              mem_rw;
   logic        [3:0] mem_address;
   logic signed [7:0] mem_data_in;
   logic signed [7:0] mem_data_out;
   logic              mem_out_valid;
`ifdef LSU_STATS_EN
   logic [7:0] stat_loads, stat_stores, stat_errs;
`endif

   int checks = 0;
   int failures = 0;
   int rw_cnt = 0;

   logic [7:0] ref_mem [8];
   logic [7:0] ref_loads = 0, ref_stores = 0, ref_errs = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl dut (
      .clk(clk), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_rw(mem_rw), .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .mem_out_valid(mem_out_valid)
`ifdef LSU_STATS_EN
      , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
   );

   // Attached data memory: registered read, cleared by clr.
   logic signed [7:0] mem_arr [8];
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 8; i++) mem_arr[i] <= 8'sd0;
         mem_data_out  <= 8'sd0;
         mem_out_valid <= 1'b0;
      end else begin
         if (mem_rw) mem_arr[mem_address[2:0]] <= mem_data_in;
         mem_data_out  <= mem_arr[mem_address[2:0]];
         mem_out_valid <= !mem_rw;
      end
   end

   always @(posedge clk) if (mem_rw) rw_cnt <= rw_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // One full request/response, checked against the reference model.
   task automatic xact(input logic we, input logic [3:0] a, input logic [7:0] d,
                       input int hold);
      logic [7:0] exp_rd, held;
      logic       exp_er;
      int         exp_lat, lat, wait_n, rw0;
      exp_er  = (a >= 4'd8);
      exp_rd  = (we || exp_er) ? 8'h00 : ref_mem[a[2:0]];
      exp_lat = exp_er ? 1 : (we ? 2 : 3);
      rw0     = rw_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      rsp_ready = (hold == 0);
      wait_n = 0;
      while (!req_ready && wait_n < 10) begin @(negedge clk); wait_n++; end
      chk("req_ready_before_xfer", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("latency", lat, exp_lat);
      chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_er});
      held = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rdata_stable", {24'd0, rsp_rdata}, {24'd0, held});
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
         req_valid = (i % 2 == 0);
         req_we = $urandom_range(0, 1); req_addr = $urandom_range(0, 15);
         req_wdata = $urandom_range(0, 255);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
      chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
      chk("mem_rw_cycles", rw_cnt - rw0, (we && !exp_er) ? 1 : 0);
      if (we && !exp_er) ref_mem[a[2:0]] = d;
      if (exp_er) ref_errs = sat_inc(ref_errs);
      else if (we) ref_stores = sat_inc(ref_stores);
      else ref_loads = sat_inc(ref_loads);
   endtask

   task automatic chk_stats(input string tag);
`ifdef LSU_STATS_EN
      chk({tag, "_loads"},  {24'd0, stat_loads},  {24'd0, ref_loads});
      chk({tag, "_stores"}, {24'd0, stat_stores}, {24'd0, ref_stores});
      chk({tag, "_errs"},   {24'd0, stat_errs},   {24'd0, ref_errs});
`else
      if (tag.len() < 0) chk(tag, 32'd0, 32'd1);
`endif
   endtask

   task automatic clear_ref();
      for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
      ref_loads = 0; ref_stores = 0; ref_errs = 0;
   endtask

   initial begin
      clear_ref();
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1;
      clr = 1;

      // Reset held for two cycles
      repeat (2) begin
         @(negedge clk);
         chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
         chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
         chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      end
      clr = 0; #1;
      chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk_stats("rst_stats");

      // Store then load, signed and boundary addresses
      xact(1'b1, 4'd3, 8'h5A, 0);
      xact(1'b0, 4'd3, 8'h00, 0);
      xact(1'b1, 4'd7, 8'h80, 0);
      xact(1'b1, 4'd0, 8'h7F, 0);
      xact(1'b0, 4'd7, 8'h00, 0);
      xact(1'b0, 4'd0, 8'h00, 0);

      // Out-of-range, then confirm memory untouched
      xact(1'b0, 4'd8, 8'h00, 0);
      xact(1'b1, 4'd15, 8'h11, 0);
      for (int i = 0; i < 8; i++) xact(1'b0, i[3:0], 8'h00, 0);

      // Backpressure on a load response
      xact(1'b0, 4'd3, 8'h00, 5);
      chk_stats("dir_stats");

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         logic [3:0] a;
         a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         xact(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      chk_stats("rand_stats");

      // Reset during the ISSUE cycle of a store
      @(negedge clk);
      req_valid = 1; req_we = 1; req_addr = 4'd2; req_wdata = 8'h33;
      @(posedge clk); #1;
      req_valid = 0;
      @(negedge clk);
      chk("issue_mem_rw", {31'd0, mem_rw}, 32'd1);
      clr = 1;
      @(posedge clk); #1;
      chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_mem_rw", {31'd0, mem_rw}, 32'd0);
      @(negedge clk);
      clr = 0; #1;
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      clear_ref();
      chk_stats("midrst_stats");
      xact(1'b0, 4'd2, 8'h00, 0);
      xact(1'b0, 4'd3, 8'h00, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
